// File: rtl/frame_stream_if.sv
// Pixel-stream / frame-load bundle between the stream source, the frame loader and the shadow register.
interface frame_stream_if #(
   parameter int DATA_SIZE_BITS = 16,
   parameter int IMG_SIDELENGTH = 64
);
   logic [DATA_SIZE_BITS-1:0] pixIn;
   logic                      pixValid;
   logic                      sofIn;
   logic                      pixReady;
   logic                      shadowBusy;
   logic                      loadEN;
   logic [IMG_SIDELENGTH-1:0][IMG_SIDELENGTH-1:0][DATA_SIZE_BITS-1:0] frameOut;
   logic                      frameErr;
   logic [15:0]               frameCount;

   modport master (
      output pixIn, pixValid, sofIn, shadowBusy,
      input  pixReady, loadEN, frameOut, frameErr, frameCount
   );

   modport slave (
      input  pixIn, pixValid, sofIn, shadowBusy,
      output pixReady, loadEN, frameOut, frameErr, frameCount
   );
endinterface

// File: rtl/frame_stream_loader.sv
// Assembles a raster-order pixel stream into an N x N working frame and strobes it into the shadow register.
//  state   | meaning
//  ST_FILL | accepting beats, writing frameOut[x][y]
//  ST_WAIT | frame complete, held off while shadowBusy
//  ST_LOAD | loadEN high for this one cycle
module frame_stream_loader #(
   parameter int DATA_SIZE_BITS = 16,
   parameter int IMG_SIDELENGTH = 64
) (
   input  logic clk,
   input  logic rst_n,
   frame_stream_if.slave fs
);
   localparam int AW = (IMG_SIDELENGTH > 1) ? $clog2(IMG_SIDELENGTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(IMG_SIDELENGTH - 1);

   typedef enum logic [1:0] {ST_FILL, ST_WAIT, ST_LOAD} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   x_q, x_d, y_q, y_d;
   logic [AW-1:0]   wr_x, wr_y;
   logic            wr_en;
   logic            err_d, err_q;
   logic            load_q;
   logic [15:0]     frame_count_q;
   logic [IMG_SIDELENGTH-1:0][IMG_SIDELENGTH-1:0][DATA_SIZE_BITS-1:0] frame_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      wr_en   = 1'b0;
      wr_x    = x_q;
      wr_y    = y_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_FILL: begin
            if (fs.pixValid) begin
               wr_en = 1'b1;
               // A start marker always wins, even on the last position, so a resync never loads.
               if (fs.sofIn) begin
                  wr_x  = '0;
                  wr_y  = '0;
                  x_d   = AW'(1);
                  y_d   = '0;
                  err_d = (x_q != '0) || (y_q != '0);
               end else if (x_q == LAST && y_q == LAST) begin
                  x_d     = '0;
                  y_d     = '0;
                  state_d = fs.shadowBusy ? ST_WAIT : ST_LOAD;
               end else if (x_q == LAST) begin
                  x_d = '0;
                  y_d = y_q + AW'(1);
               end else begin
                  x_d = x_q + AW'(1);
               end
            end
         end
         ST_WAIT: begin
            if (!fs.shadowBusy) state_d = ST_LOAD;
         end
         ST_LOAD: state_d = ST_FILL;
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_FILL;
         x_q           <= '0;
         y_q           <= '0;
         err_q         <= 1'b0;
         load_q        <= 1'b0;
         frame_count_q <= '0;
         frame_q       <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         err_q   <= err_d;
         load_q  <= (state_d == ST_LOAD);
         if (state_d == ST_LOAD) frame_count_q <= frame_count_q + 16'd1;
         if (wr_en) frame_q[wr_x][wr_y] <= fs.pixIn;
      end
   end

   assign fs.pixReady   = (state_q == ST_FILL);
   assign fs.loadEN     = load_q;
   assign fs.frameErr   = err_q;
   assign fs.frameCount = frame_count_q;
   assign fs.frameOut   = frame_q;
endmodule

// File: tb/tb_frame_stream_loader.sv
// Bench for frame_stream_loader at N=4: linear-index frame model checked every cycle plus directed literal checks.
module tb_frame_stream_loader;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int NP = N * N;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   frame_stream_if #(.DATA_SIZE_BITS(W), .IMG_SIDELENGTH(N)) fs();

   frame_stream_loader #(.DATA_SIZE_BITS(W), .IMG_SIDELENGTH(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fs    (fs)
   );

   int tests = 0;
   int fails = 0;
   int loads_seen = 0;
   int errs_seen = 0;
   int notrdy_seen = 0;
   logic        preset_en = 1'b0;
   logic [15:0] preset_val = 16'h0;

   logic [N-1:0][N-1:0][W-1:0] m_frame;
   int          m_p;
   bit          m_cmpl, m_load, m_err, m_ready;
   logic [15:0] m_count;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: p is the linear raster index (x = p % N, y = p / N); a completed frame
   // loads on the first edge where shadowBusy is low, and the load lasts one cycle.
   always @(posedge clk or negedge rst_n) begin : model
      logic [N-1:0][N-1:0][W-1:0] fr;
      int          p;
      bit          cmpl, ld, er;
      logic [15:0] cnt;
      if (!rst_n) begin
         m_frame <= '0;
         m_p     <= 0;
         m_cmpl  <= 1'b0;
         m_load  <= 1'b0;
         m_err   <= 1'b0;
         m_ready <= 1'b1;
         m_count <= '0;
      end else begin
         fr = m_frame; p = m_p; cmpl = m_cmpl; ld = 1'b0; er = 1'b0; cnt = m_count;
         if (preset_en) cnt = preset_val;
         if (m_load) begin
            ld = 1'b0;
         end else if (cmpl) begin
            if (!fs.shadowBusy) begin cmpl = 1'b0; ld = 1'b1; cnt = cnt + 16'd1; end
         end else if (fs.pixValid) begin
            if (fs.sofIn) begin
               er = (p != 0);
               fr[0][0] = fs.pixIn;
               p = 1;
            end else begin
               fr[2'(p % N)][2'(p / N)] = fs.pixIn;
               p = p + 1;
               if (p == NP) begin
                  p = 0;
                  if (fs.shadowBusy) cmpl = 1'b1;
                  else begin ld = 1'b1; cnt = cnt + 16'd1; end
               end
            end
         end
         m_frame <= fr;
         m_p     <= p;
         m_cmpl  <= cmpl;
         m_load  <= ld;
         m_err   <= er;
         m_ready <= !cmpl && !ld;
         m_count <= cnt;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("pixReady",   256'(fs.pixReady),   256'(m_ready));
         chk("loadEN",     256'(fs.loadEN),     256'(m_load));
         chk("frameErr",   256'(fs.frameErr),   256'(m_err));
         chk("frameCount", 256'(fs.frameCount), 256'(m_count));
         chk("frameOut",   256'(fs.frameOut),   256'(m_frame));
         if (fs.loadEN === 1'b1) loads_seen++;
         if (fs.frameErr === 1'b1) errs_seen++;
         if (fs.pixReady === 1'b0) notrdy_seen++;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic send(input logic [15:0] v, input bit sof);
      bit r;
      int guard;
      fs.pixIn = v; fs.sofIn = sof; fs.pixValid = 1'b1;
      r = 1'b0; guard = 0;
      while (!r) begin
         @(negedge clk);
         r = fs.pixReady;
         @(posedge clk); #2;
         guard++;
         if (!r && guard > 100) begin
            tests++; fails++;
            $display("FAIL send_timeout: beat %0h not accepted within %0d cycles", v, guard);
            r = 1'b1;
         end
      end
      fs.pixValid = 1'b0; fs.sofIn = 1'b0;
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_ready"}, 256'(fs.pixReady),   256'(1));
      chk({nm, "_load"},  256'(fs.loadEN),     256'(0));
      chk({nm, "_err"},   256'(fs.frameErr),   256'(0));
      chk({nm, "_count"}, 256'(fs.frameCount), 256'(0));
      chk({nm, "_frame"}, 256'(fs.frameOut),   256'(0));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: bench did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int l0, e0, n0;
      fs.pixIn = '0; fs.pixValid = 1'b0; fs.sofIn = 1'b0; fs.shadowBusy = 1'b0;
      idle(2);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      idle(2);

      // 1: clean frame, no backpressure
      l0 = loads_seen; n0 = notrdy_seen;
      for (int i = 0; i < NP; i++) send(16'(i), 1'b0);
      idle(3);
      chk("t1_loads",  256'(loads_seen - l0),  256'(1));
      chk("t1_notrdy", 256'(notrdy_seen - n0), 256'(1));
      chk("t1_count",  256'(fs.frameCount),    256'(1));
      for (int x = 0; x < N; x++)
         for (int y = 0; y < N; y++)
            chk("t1_pix", 256'(fs.frameOut[2'(x)][2'(y)]), 256'(4 * y + x));

      // 2: shadowBusy held for 5 cycles after the last beat
      l0 = loads_seen;
      for (int i = 0; i < NP - 1; i++) send(16'(100 + i), 1'b0);
      fs.shadowBusy = 1'b1;
      n0 = notrdy_seen;
      send(16'(115), 1'b0);
      idle(4);
      fs.shadowBusy = 1'b0;
      idle(3);
      chk("t2_loads",  256'(loads_seen - l0),  256'(1));
      chk("t2_notrdy", 256'(notrdy_seen - n0), 256'(6));
      chk("t2_count",  256'(fs.frameCount),    256'(2));
      chk("t2_pix33",  256'(fs.frameOut[3][3]), 256'(115));

      // 3: resync mid-frame
      l0 = loads_seen; e0 = errs_seen;
      for (int i = 0; i < 6; i++) send(16'(200 + i), 1'b0);
      send(16'hAAAA, 1'b1);
      for (int i = 0; i < NP - 1; i++) send(16'(300 + i), 1'b0);
      idle(3);
      chk("t3_errs",  256'(errs_seen - e0),    256'(1));
      chk("t3_loads", 256'(loads_seen - l0),   256'(1));
      chk("t3_pix00", 256'(fs.frameOut[0][0]), 256'(16'hAAAA));
      chk("t3_pix10", 256'(fs.frameOut[1][0]), 256'(300));
      chk("t3_count", 256'(fs.frameCount),     256'(3));

      // 4: random valid gaps over 3 frames
      l0 = loads_seen;
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < NP; i++) begin
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
            send(16'($urandom), 1'b0);
         end
      idle(3);
      chk("t4_loads", 256'(loads_seen - l0), 256'(3));
      chk("t4_count", 256'(fs.frameCount),   256'(6));

      // 5: reset mid-frame, then a fresh frame
      for (int i = 0; i < 9; i++) send(16'(500 + i), 1'b0);
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("t5_rst");
      idle(2);
      rst_n = 1'b1;
      l0 = loads_seen;
      for (int i = 0; i < NP; i++) send(16'(400 + i), 1'b0);
      idle(3);
      chk("t5_loads", 256'(loads_seen - l0),   256'(1));
      chk("t5_count", 256'(fs.frameCount),     256'(1));
      chk("t5_pix33", 256'(fs.frameOut[3][3]), 256'(415));

      // reset while waiting on shadowBusy drops the pending load
      l0 = loads_seen;
      fs.shadowBusy = 1'b1;
      for (int i = 0; i < NP; i++) send(16'(600 + i), 1'b0);
      idle(1);
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("wait_rst");
      fs.shadowBusy = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(3);
      chk("wait_rst_loads", 256'(loads_seen - l0), 256'(0));

      // sofIn on the final position resyncs instead of loading
      l0 = loads_seen; e0 = errs_seen;
      for (int i = 0; i < NP - 1; i++) send(16'(700 + i), 1'b0);
      send(16'h5555, 1'b1);
      idle(3);
      chk("lastsof_errs",  256'(errs_seen - e0),  256'(1));
      chk("lastsof_loads", 256'(loads_seen - l0), 256'(0));
      for (int i = 0; i < NP - 1; i++) send(16'(800 + i), 1'b0);
      idle(3);
      chk("lastsof_loads2", 256'(loads_seen - l0),   256'(1));
      chk("lastsof_pix00",  256'(fs.frameOut[0][0]), 256'(16'h5555));
      chk("lastsof_count",  256'(fs.frameCount),     256'(1));

      // 6: counter wrap, preset near the limit
      @(negedge clk); #1;
      force dut.frame_count_q = 16'hFFFE;
      preset_val = 16'hFFFE; preset_en = 1'b1;
      @(posedge clk); #2;
      release dut.frame_count_q;
      preset_en = 1'b0;
      l0 = loads_seen;
      for (int i = 0; i < NP; i++) send(16'(900 + i), 1'b0);
      idle(3);
      chk("t6_count_ffff", 256'(fs.frameCount), 256'(16'hFFFF));
      for (int i = 0; i < NP; i++) send(16'(950 + i), 1'b0);
      idle(3);
      chk("t6_count_wrap", 256'(fs.frameCount),   256'(16'h0000));
      chk("t6_loads",      256'(loads_seen - l0), 256'(2));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
